// File: rtl/fetch_bundle_queue_pkg.sv
// Shared types and constants for the SPU-lite bundle fetch unit.
package fetch_bundle_queue_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned OPC_W  = 11;

    // Even-pipe nop and odd-pipe lnop encodings used for padding slots.
    localparam logic [INST_W-1:0] NOP_EVEN = {11'b00000000001, 21'b0};
    localparam logic [INST_W-1:0] NOP_ODD  = {11'b01000000001, 21'b0};

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DONE  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // Padding word for a slot: even slots feed the even pipe, odd slots the odd pipe.
    function automatic logic [INST_W-1:0] nop_for_slot(input int unsigned slot);
        return ((slot % 2) != 0) ? NOP_ODD : NOP_EVEN;
    endfunction

endpackage

// File: rtl/fetch_bundle_queue_if.sv
// Loader, control and issue signals of the bundle fetch unit.
interface fetch_bundle_queue_if #(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned IMEM_WORDS  = 512,
    parameter int unsigned QUEUE_DEPTH = 4
);
    localparam int unsigned ADDR_W = $clog2(IMEM_WORDS);
    localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH) + 1;

    logic                     stall;
    logic                     branch_taken;
    logic [31:0]              branch_target;
    logic                     imem_we;
    logic [ADDR_W-1:0]        imem_waddr;
    logic [31:0]              imem_wdata;
    logic [32*ISSUE_WIDTH-1:0] issue_inst;
    logic [ISSUE_WIDTH-1:0]   issue_slot_vld;
    logic                     issue_valid;
    logic [31:0]              issue_pc;
    logic [CNT_W-1:0]         queue_count;
    logic                     halted;

    modport master (
        output stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
        input  issue_inst, issue_slot_vld, issue_valid, issue_pc, queue_count, halted
    );

    modport slave (
        input  stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
        output issue_inst, issue_slot_vld, issue_valid, issue_pc, queue_count, halted
    );
endinterface

// File: rtl/fetch_bundle_queue_bundle_fifo.sv
// Synchronous FIFO of fetch bundles with a single-cycle flush.
module bundle_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head_c,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head_c  = mem[rd_ptr];

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fetch_bundle_queue.sv
// Multi-issue fetch: instruction store -> bundle assembly -> bundle FIFO -> issue register.
module fetch_bundle_queue
    import fetch_bundle_queue_pkg::*;
#(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned IMEM_WORDS  = 512,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input logic                 clock,
    input logic                 reset,
    fetch_bundle_queue_if.slave bus
);
    localparam int unsigned LOG_W        = $clog2(ISSUE_WIDTH);
    localparam int unsigned ADDR_W       = $clog2(IMEM_WORDS);
    localparam int unsigned CNT_W        = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned BUNDLE_BYTES = 4 * ISSUE_WIDTH;

    typedef struct packed {
        logic [ISSUE_WIDTH-1:0][INST_W-1:0] inst;
        logic [ISSUE_WIDTH-1:0]             slot_vld;
        logic [31:0]                        pc;
    } bundle_t;

    logic [INST_W-1:0] imem [IMEM_WORDS];

    fetch_state_e state, state_d;
    logic [31:0]  fetch_pc, fetch_pc_d;
    logic [31:0]  word_idx, base_idx, bundle_pc;
    logic [LOG_W-1:0] lead;

    logic [ISSUE_WIDTH-1:0][INST_W-1:0] asm_inst, nop_inst;
    logic [ISSUE_WIDTH-1:0]             asm_vld;
    bundle_t      asm_b, nop_b, head_c, issue_q;
    logic         term_hit, all_pad;
    logic         push, pop, flush, full, empty;
    logic [CNT_W-1:0] fifo_count;
    logic         stall_q, halted_q;

    // Loader write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (bus.imem_we) begin
            imem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    assign word_idx  = fetch_pc >> 2;
    assign base_idx  = word_idx & ~32'(ISSUE_WIDTH - 1);
    assign bundle_pc = base_idx << 2;
    assign lead      = LOG_W'(word_idx);

    // Per-slot read and terminator detect; run marks slots from lead up to the first terminator.
    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_slot
        logic [31:0]       idx;
        logic              in_range;
        logic [INST_W-1:0] word;
        logic              term;
        logic              run;

        assign idx      = base_idx + 32'(g);
        assign in_range = idx < 32'(IMEM_WORDS);
        assign word     = in_range ? imem[ADDR_W'(idx)] : '0;
        assign term     = !in_range || (word[INST_W-1 -: OPC_W] == '0);

        if (g == 0) begin : g_first
            assign run = (lead == '0) && !term;
        end else begin : g_next
            assign run = !term && ((32'(lead) == 32'(g)) || g_slot[g-1].run);
        end

        assign asm_inst[ISSUE_WIDTH-1-g] = run ? word : nop_for_slot(g);
        assign asm_vld[ISSUE_WIDTH-1-g]  = run;
        assign nop_inst[ISSUE_WIDTH-1-g] = nop_for_slot(g);
    end

    // A bundle that does not run to its last slot hit a terminator.
    assign term_hit = !g_slot[ISSUE_WIDTH-1].run;
    assign all_pad  = (asm_vld == '0);
    assign asm_b    = '{inst: asm_inst, slot_vld: asm_vld, pc: bundle_pc};
    assign nop_b    = '{inst: nop_inst, slot_vld: '0, pc: '0};

    assign full  = (fifo_count == CNT_W'(QUEUE_DEPTH));
    assign empty = (fifo_count == '0);

    bundle_fifo #(
        .T     (bundle_t),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (asm_b),
        .pop       (pop),
        .head_c    (head_c),
        .count     (fifo_count)
    );

    // Fetch state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= '0;
        end else begin
            state    <= state_d;
            fetch_pc <= fetch_pc_d;
        end
    end

    // Next state, fetch pointer and FIFO controls; a redirect overrides everything.
    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        if (bus.branch_taken) begin
            flush      = 1'b1;
            state_d    = FETCH;
            fetch_pc_d = bus.branch_target & ~32'd3;
        end else begin
            pop = !bus.stall && !empty;
            case (state)
                FETCH: begin
                    if (!full) begin
                        if (all_pad) begin
                            state_d = DONE;
                        end else begin
                            push       = 1'b1;
                            fetch_pc_d = bundle_pc + 32'(BUNDLE_BYTES);
                            if (term_hit) state_d = DONE;
                        end
                    end
                end
                DONE:    if (empty) state_d = HALT;
                HALT:    state_d = HALT;
                default: state_d = FETCH;
            endcase
        end
    end

    // Issue register: pop head, pad with nops when empty, hold under stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            issue_q  <= nop_b;
            bus.issue_valid <= 1'b0;
            stall_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            stall_q  <= bus.stall;
            halted_q <= (state_d == HALT);
            if (bus.branch_taken) begin
                issue_q         <= nop_b;
                bus.issue_valid <= 1'b0;
            end else if (!bus.stall) begin
                issue_q         <= empty ? nop_b : head_c;
                bus.issue_valid <= !empty;
            end else if (stall_q) begin
                bus.issue_valid <= 1'b0;
            end
        end
    end

    assign bus.issue_inst     = issue_q.inst;
    assign bus.issue_slot_vld = issue_q.slot_vld;
    assign bus.issue_pc       = issue_q.pc;
    assign bus.queue_count    = fifo_count;
    assign bus.halted         = halted_q;
endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Randomized and directed bench for fetch_bundle_queue against a queue-based model.
module tb_fetch_bundle_queue;
    import fetch_bundle_queue_pkg::*;

    localparam int unsigned W  = 2;
    localparam int unsigned IW = 64;
    localparam int unsigned QD = 4;
    localparam logic [31:0] L_NOP  = 32'h0020_0000;
    localparam logic [31:0] L_LNOP = 32'h4020_0000;

    typedef struct packed {
        logic [W-1:0][31:0] inst;
        logic [W-1:0]       vld;
        logic [31:0]        pc;
    } mb_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fetch_bundle_queue_if #(.ISSUE_WIDTH(W), .IMEM_WORDS(IW), .QUEUE_DEPTH(QD)) bus ();

    fetch_bundle_queue #(.ISSUE_WIDTH(W), .IMEM_WORDS(IW), .QUEUE_DEPTH(QD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [31:0]  m_mem [IW];
    mb_t          mq [$];
    mb_t          m_out;
    logic [31:0]  m_pc;
    fetch_state_e m_mode;
    bit           m_valid, m_halted, m_stall_prev;
    mb_t          dlog [$];
    logic [31:0]  prog [IW];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic mb_t nop_b();
        mb_t b;
        for (int unsigned i = 0; i < W; i++) b.inst[W-1-i] = (i % 2 != 0) ? L_LNOP : L_NOP;
        b.vld = '0;
        b.pc  = '0;
        return b;
    endfunction

    function automatic mb_t log_at(input int k);
        if (k < dlog.size()) return dlog[k];
        return '0;
    endfunction

    // Reference behaviour evaluated once per rising edge from pre-edge state and inputs.
    task automatic model_step();
        int unsigned pre, w, base, lead, idx;
        bit  term;
        mb_t b;
        if (reset) begin
            mq.delete();
            m_pc = '0; m_mode = FETCH; m_out = nop_b();
            m_valid = 0; m_halted = 0; m_stall_prev = 0;
        end else if (bus.branch_taken) begin
            mq.delete();
            m_pc = bus.branch_target & ~32'd3; m_mode = FETCH; m_out = nop_b();
            m_valid = 0; m_halted = 0; m_stall_prev = bus.stall;
        end else begin
            pre = mq.size();
            if (!bus.stall) begin
                if (pre > 0) begin m_out = mq.pop_front(); m_valid = 1; end
                else begin m_out = nop_b(); m_valid = 0; end
            end else if (m_stall_prev) begin
                m_valid = 0;
            end
            if (m_mode == FETCH && pre < QD) begin
                w = m_pc / 4; base = w - (w % W); lead = w % W; term = 0;
                b = nop_b(); b.pc = 32'(base * 4);
                for (int unsigned i = 0; i < W; i++) begin
                    idx = base + i;
                    if (i >= lead && !term) begin
                        if (idx >= IW || m_mem[idx][31:21] == 11'd0) term = 1;
                        else begin b.inst[W-1-i] = m_mem[idx]; b.vld[W-1-i] = 1'b1; end
                    end
                end
                if (b.vld == '0) m_mode = DONE;
                else begin
                    mq.push_back(b);
                    m_pc = 32'(base * 4 + 4 * W);
                    if (term) m_mode = DONE;
                end
            end else if (m_mode == DONE && pre == 0) begin
                m_mode = HALT;
            end
            m_halted = (m_mode == HALT);
            m_stall_prev = bus.stall;
        end
        if (bus.imem_we) m_mem[bus.imem_waddr] = bus.imem_wdata;
    endtask

    // Per-cycle comparison of every output against the model; also logs issued bundles.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("issue_valid", 128'(bus.issue_valid), 128'(m_valid));
            chk("issue_slot_vld", 128'(bus.issue_slot_vld), 128'(m_out.vld));
            chk("issue_inst", 128'(bus.issue_inst), 128'(m_out.inst));
            chk("queue_count", 128'(bus.queue_count), 128'(mq.size()));
            chk("halted", 128'(bus.halted), 128'(m_halted));
            if (m_valid || m_out.vld != '0) chk("issue_pc", 128'(bus.issue_pc), 128'(m_out.pc));
            if (bus.issue_valid)
                dlog.push_back('{inst: bus.issue_inst, vld: bus.issue_slot_vld, pc: bus.issue_pc});
        end
    end

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        #1;
    endtask

    task automatic load_prog();
        reset = 1'b1;
        for (int i = 0; i < IW; i++) begin
            bus.imem_we = 1'b1; bus.imem_waddr = 6'(i); bus.imem_wdata = prog[i];
            cycle();
        end
        bus.imem_we = 1'b0;
        reset = 1'b0;
    endtask

    task automatic set_prog(input int n);
        for (int i = 0; i < IW; i++) prog[i] = (i < n) ? (32'h1000_0000 | 32'(i)) : 32'h0;
    endtask

    initial begin
        mb_t e;
        reset = 1'b1;
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
        cycle();
        chk_en = 1'b1;

        // Reset values pinned to literals.
        chk("rst_inst", 128'(bus.issue_inst), 128'({L_NOP, L_LNOP}));
        chk("rst_slot_vld", 128'(bus.issue_slot_vld), 128'(0));
        chk("rst_valid", 128'(bus.issue_valid), 128'(0));
        chk("rst_pc", 128'(bus.issue_pc), 128'(0));
        chk("rst_count", 128'(bus.queue_count), 128'(0));

        // Six words then terminator: three full bundles, then halt.
        set_prog(6); load_prog();
        dlog.delete();
        repeat (12) cycle();
        chk("a_nbundles", 128'(dlog.size()), 128'(3));
        for (int j = 0; j < 3; j++) begin
            e = log_at(j);
            chk("a_pc", 128'(e.pc), 128'(8 * j));
            chk("a_vld", 128'(e.vld), 128'(2'b11));
            chk("a_inst", 128'(e.inst), 128'({prog[2*j], prog[2*j+1]}));
        end
        chk("a_halted", 128'(bus.halted), 128'(1));

        // Redirect out of HALT replays from 0.
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0;
        cycle();
        bus.branch_taken = 1'b0;
        chk("e_halted", 128'(bus.halted), 128'(0));
        chk("e_count", 128'(bus.queue_count), 128'(0));
        dlog.delete();
        repeat (12) cycle();
        chk("e_nbundles", 128'(dlog.size()), 128'(3));
        for (int j = 0; j < 3; j++) chk("e_pc", 128'(log_at(j).pc), 128'(8 * j));

        // Five words: last bundle is word4 plus lnop.
        set_prog(5); load_prog();
        dlog.delete();
        repeat (12) cycle();
        e = log_at(2);
        chk("b_nbundles", 128'(dlog.size()), 128'(3));
        chk("b_inst", 128'(e.inst), 128'({32'h1000_0004, L_LNOP}));
        chk("b_vld", 128'(e.vld), 128'(2'b10));
        chk("b_pc", 128'(e.pc), 128'(16));
        chk("b_halted", 128'(bus.halted), 128'(1));

        // Stall from reset: queue fills, then drains in order.
        set_prog(48); bus.stall = 1'b1; load_prog();
        repeat (10) cycle();
        chk("c_count_full", 128'(bus.queue_count), 128'(4));
        bus.stall = 1'b0;
        dlog.delete();
        repeat (8) cycle();
        for (int j = 0; j < 5; j++) chk("c_pc", 128'(log_at(j).pc), 128'(8 * j));

        // Misaligned redirect mid-stream.
        bus.branch_taken = 1'b1; bus.branch_target = 32'h14;
        cycle();
        bus.branch_taken = 1'b0;
        chk("d_valid", 128'(bus.issue_valid), 128'(0));
        chk("d_count", 128'(bus.queue_count), 128'(0));
        dlog.delete();
        repeat (4) cycle();
        e = log_at(0);
        chk("d_pc0", 128'(e.pc), 128'(32'h10));
        chk("d_vld0", 128'(e.vld), 128'(2'b01));
        chk("d_inst0", 128'(e.inst), 128'({L_NOP, 32'h1000_0005}));
        chk("d_pc1", 128'(log_at(1).pc), 128'(32'h18));

        // Reset with the queue three-quarters full.
        reset = 1'b1; cycle(); reset = 1'b0;
        repeat (3) cycle();
        bus.stall = 1'b1;
        repeat (2) cycle();
        chk("f_count3", 128'(bus.queue_count), 128'(3));
        reset = 1'b1; cycle(); reset = 1'b0; bus.stall = 1'b0;
        chk("f_inst", 128'(bus.issue_inst), 128'({L_NOP, L_LNOP}));
        chk("f_valid", 128'(bus.issue_valid), 128'(0));
        chk("f_count", 128'(bus.queue_count), 128'(0));
        chk("f_pc", 128'(bus.issue_pc), 128'(0));

        // Randomized programs, stalls, redirects and resets; last round has no zero words.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < IW; i++)
                prog[i] = (r != 2 && $urandom % 10 == 0) ? ($urandom & 32'h001F_FFFF)
                                                          : ($urandom | 32'h0020_0000);
            bus.stall = 1'b0;
            load_prog();
            for (int c = 0; c < 800; c++) begin
                bus.stall         = ($urandom % 10) < 3;
                bus.branch_taken  = ($urandom % 25) == 0;
                bus.branch_target = $urandom_range(0, 4 * IW + 15);
                reset             = ($urandom % 150) == 0;
                cycle();
            end
            reset = 1'b0; bus.branch_taken = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
